// File: rtl/fdd_index_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fdd_index_monitor_if                                          |
// | Brief    : Tick/INDEX/motor inputs and rotation status outputs of the     |
// |            FDD index monitor.                                            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface fdd_index_monitor_if #(
  parameter int PERIOD_W = 20
);
  logic                tick_en;
  logic                index_n;
  logic                motor_on;
  logic                index_pulse;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                spinning;
  logic                timeout;

  modport master (
    output tick_en, index_n, motor_on,
    input  index_pulse, period, period_valid, spinning, timeout
  );

  modport slave (
    input  tick_en, index_n, motor_on,
    output index_pulse, period, period_valid, spinning, timeout
  );
endinterface
`default_nettype wire

// File: rtl/fdd_index_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fdd_index_monitor                                             |
// | Brief    : Filters the drive INDEX line, measures rotation period in     |
// |            ticks and reports lock / loss of rotation.                    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fdd_index_monitor #(
  parameter int PERIOD_W      = 20,
  parameter int FILTER_TICKS  = 4,
  parameter int MIN_PERIOD    = 190000,
  parameter int MAX_PERIOD    = 210000,
  parameter int TIMEOUT_TICKS = 600000,
  parameter int LOCK_COUNT    = 2
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  fdd_index_monitor_if.slave bus
);

  localparam int c_FILT_W = (FILTER_TICKS > 1) ? $clog2(FILTER_TICKS) : 1;
  localparam int c_LOCK_W = $clog2(LOCK_COUNT + 1);

  localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_TICKS - 1);
  localparam logic [c_LOCK_W-1:0] c_LOCK_MAX  = c_LOCK_W'(LOCK_COUNT);
  localparam logic [PERIOD_W-1:0] c_MIN       = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] c_MAX       = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] c_TIMEOUT   = PERIOD_W'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEEK    = 2'd1,
    S_MEASURE = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  logic                r_sync1, r_sync2;
  logic                r_filt, r_filt_q;
  logic [c_FILT_W-1:0] r_stab;
  state_t              r_state, w_state_nxt;
  logic [PERIOD_W-1:0] r_cnt, w_cnt_nxt;
  logic [c_LOCK_W-1:0] r_lock, w_lock_nxt;
  logic [PERIOD_W-1:0] r_period, w_period_nxt;
  logic                r_pulse, w_pulse_nxt;
  logic                r_pv, w_pv_nxt;
  logic                r_spin, w_spin_nxt;
  logic                r_to, w_to_nxt;

  logic                w_fall;
  logic                w_in_window;
  logic                w_cnt_sat;
  logic [c_LOCK_W-1:0] w_lock_inc;

  // INDEX synchronizer and tick-based glitch filter; filtered level idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_q <= 1'b1;
      r_stab   <= '0;
    end else begin
      r_sync1  <= bus.index_n;
      r_sync2  <= r_sync1;
      r_filt_q <= r_filt;
      if (r_sync2 == r_filt) begin
        r_stab <= '0;
      end else if (bus.tick_en) begin
        if (r_stab == c_FILT_LAST) begin
          r_filt <= r_sync2;
          r_stab <= '0;
        end else begin
          r_stab <= r_stab + 1'b1;
        end
      end
    end
  end

  // Fall is seen the cycle after the filter settles low, so the tick that
  // moved the filter is already included in the counter.
  assign w_fall      = r_filt_q & ~r_filt;
  assign w_in_window = (r_cnt >= c_MIN) && (r_cnt <= c_MAX);
  assign w_cnt_sat   = (r_cnt == c_TIMEOUT);
  assign w_lock_inc  = (r_lock == c_LOCK_MAX) ? r_lock : r_lock + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_lock   <= '0;
      r_period <= '0;
      r_pulse  <= 1'b0;
      r_pv     <= 1'b0;
      r_spin   <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_lock   <= w_lock_nxt;
      r_period <= w_period_nxt;
      r_pulse  <= w_pulse_nxt;
      r_pv     <= w_pv_nxt;
      r_spin   <= w_spin_nxt;
      r_to     <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_lock_nxt   = r_lock;
    w_period_nxt = r_period;
    w_pulse_nxt  = 1'b0;
    w_pv_nxt     = 1'b0;
    w_spin_nxt   = r_spin;
    w_to_nxt     = 1'b0;

    if (bus.tick_en && !w_cnt_sat) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
    if (w_fall) begin
      w_cnt_nxt = '0;
    end

    if (!bus.motor_on) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_lock_nxt  = '0;
      w_spin_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SEEK;
        end
        S_SEEK: begin
          w_pulse_nxt = w_fall;
          if (w_fall) begin
            w_state_nxt = S_MEASURE;
          end
        end
        S_MEASURE, S_LOCKED: begin
          w_pulse_nxt = w_fall;
          if (w_fall) begin
            // A fall on the saturated count lands here as an out-of-window period.
            w_period_nxt = r_cnt;
            w_pv_nxt     = 1'b1;
            if (w_in_window) begin
              w_lock_nxt = w_lock_inc;
              if (w_lock_inc == c_LOCK_MAX) begin
                w_state_nxt = S_LOCKED;
                w_spin_nxt  = 1'b1;
              end
            end else begin
              w_lock_nxt  = '0;
              w_spin_nxt  = 1'b0;
              w_state_nxt = S_MEASURE;
            end
          end else if (w_cnt_sat) begin
            w_to_nxt    = 1'b1;
            w_spin_nxt  = 1'b0;
            w_lock_nxt  = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_SEEK;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.index_pulse  = r_pulse;
  assign bus.period       = r_period;
  assign bus.period_valid = r_pv;
  assign bus.spinning     = r_spin;
  assign bus.timeout      = r_to;

endmodule
`default_nettype wire
